// File: rtl/fetch_boot_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding and defaults for the fetch boot controller
package fetch_ctrl_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    HALT    = 3'd4
  } state_e;
  localparam logic [15:0] HALT_INSTR_DEF = 16'h0000;
endpackage

// File: rtl/fetch_boot_ctrl_load_addr_counter.sv
// load_addr_counter: IM write pointer and load word count with clear, increment and terminal flag
module load_addr_counter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   count,
  output logic              term
);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  assign term   = &wr_ptr_q;
  assign wr_ptr = wr_ptr_q;
  assign count  = count_q;
  always_comb begin
    wr_ptr_d = clr ? '0 : (inc && !term) ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = clr ? '0 : inc ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fetch_boot_ctrl.sv
// fetch_boot_ctrl: sequences program load, PC release, run and halt of the fetch datapath
module fetch_boot_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter int                FETCH_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               run_start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  input  logic [ADDR_W-1:0]  pc_address,
  input  logic [DATA_W-1:0]  instr_word,
  input  logic               ext_stall,
  output logic               im_en_write,
  output logic [ADDR_W-1:0]  im_address,
  output logic [DATA_W-1:0]  im_data_in,
  output logic               pc_reset,
  output logic               pc_stall,
  output logic               halted,
  output logic               load_overflow,
  output logic [ADDR_W:0]    load_count,
  output logic [STATE_W-1:0] state
);
  localparam int ARM_W = $clog2(FETCH_LAT + 2);
  state_e            state_q, state_d;
  logic [ARM_W-1:0]  arm_q, arm_d;
  logic              ovf_q, ovf_d;
  logic              accept, halt_hit, start_load, term;
  logic [ADDR_W-1:0] wr_ptr;
  assign load_ready  = (state_q == LOAD) & ~reset;
  assign accept      = load_valid & load_ready;
  assign start_load  = load_start & ((state_q == IDLE) | (state_q == HALT));
  assign halt_hit    = (state_q == RUN) && (arm_q == '0) && !ext_stall && (instr_word == HALT_INSTR);
  assign im_en_write = accept;
  assign im_address  = (state_q == LOAD) ? wr_ptr : pc_address;
  assign im_data_in  = load_data;
  assign pc_reset    = !((state_q == RUN) || (state_q == HALT));
  assign pc_stall    = (state_q == RUN) ? (ext_stall | halt_hit) : 1'b1;
  assign halted      = state_q == HALT;
  assign load_overflow = ovf_q;
  assign state       = state_q;
  load_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (start_load),
    .inc    (accept),
    .wr_ptr (wr_ptr),
    .count  (load_count),
    .term   (term)
  );
  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, HALT: begin
        state_d = load_start ? LOAD : run_start ? RELEASE : state_q;
        ovf_d   = load_start ? 1'b0 : ovf_q;
      end
      LOAD: begin
        state_d = (accept && (load_last || term)) ? RELEASE : LOAD;
        ovf_d   = ovf_q | (accept & term & ~load_last);
      end
      RELEASE: begin
        state_d = RUN;
        arm_d   = ARM_W'(FETCH_LAT);
      end
      RUN: begin
        state_d = halt_hit ? HALT : RUN;
        arm_d   = (!ext_stall && arm_q != '0) ? arm_q - 1'b1 : arm_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      arm_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
